instruction_aligner: RTL



---
 rtl/instruction_aligner_pkg.sv | 23 ++
 rtl/instruction_aligner.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_aligner_pkg.sv
// -----------------------------------------------------------------------------
// instruction_aligner_pkg
// Shared definitions for the instruction aligner: FSM state encoding, the NOP
// pattern used as the idle output value, and the RVC compressed-halfword test.
// -----------------------------------------------------------------------------
package instruction_aligner_pkg;

    // Aligner state: whether a leftover halfword is buffered, or the low half
    // of the next fetched word must be dropped after a halfword-aligned redirect.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HALF  = 2'd1,
        S_SKIP  = 2'd2
    } aligner_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // A halfword starts a compressed instruction unless its low two bits are 11.
    function automatic logic is_compressed(input logic [15:0] half);
        return (half[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/instruction_aligner.sv
// -----------------------------------------------------------------------------
// instruction_aligner
// Turns a stream of word-aligned 32-bit fetch words into one instruction per
// output handshake: a 16-bit compressed instruction (zero-extended) or a full
// 32-bit instruction, each tagged with its PC. 32-bit instructions straddling
// a word boundary are stitched from a buffered upper halfword; redirects to
// halfword-aligned targets drop the unused low half of the first word.
//
// Ports:
//   clk            in   system clock
//   reset_n        in   synchronous active-low reset
//   fetch_valid    in   fetch_data holds the next sequential word
//   fetch_data     in   32-bit fetch word, little-endian halfwords
//   fetch_ready    out  word accepted when fetch_valid && fetch_ready
//   flush          in   redirect, discards buffered and in-flight state
//   flush_pc       in   redirect target (bit 0 ignored)
//   out_valid      out  out_instr/out_pc valid
//   out_ready      in   downstream accepts the output
//   out_instr      out  raw instruction, compressed as {16'h0, half}
//   out_compressed out  out_instr[1:0] != 2'b11
//   out_pc         out  PC of out_instr
// -----------------------------------------------------------------------------
module instruction_aligner
    import instruction_aligner_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_data,
    output logic        fetch_ready,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_compressed,
    output logic [31:0] out_pc
);

    aligner_state_t r_state;
    aligner_state_t w_state_nxt;
    logic [31:0]    r_pc;
    logic [31:0]    w_pc_nxt;
    logic [15:0]    r_hold;
    logic [15:0]    w_hold_nxt;

    logic           r_out_valid;
    logic [31:0]    r_out_instr;
    logic           r_out_compressed;
    logic [31:0]    r_out_pc;

    logic           w_load_en;
    logic           w_fetch_ready;
    logic           w_accept;
    logic           w_emit;
    logic [31:0]    w_emit_instr;
    logic           w_hold_comp;
    logic           w_low_comp;
    logic           w_unused_flush_lsb;

    // Output register may be overwritten when empty or being consumed.
    assign w_load_en          = !r_out_valid || out_ready;
    assign w_accept           = fetch_valid && w_fetch_ready;
    assign w_hold_comp        = is_compressed(r_hold);
    assign w_low_comp         = is_compressed(fetch_data[15:0]);
    assign w_unused_flush_lsb = flush_pc[0];

    assign fetch_ready    = w_fetch_ready;
    assign out_valid      = r_out_valid;
    assign out_instr      = r_out_instr;
    assign out_compressed = r_out_compressed;
    assign out_pc         = r_out_pc;

    // State register: FSM state, current PC and the buffered upper halfword.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_EMPTY;
            r_pc    <= RESET_PC;
            r_hold  <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Next-state logic: PC advance and halfword buffering per state; flush wins.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_hold_nxt  = r_hold;
        if (flush) begin
            w_pc_nxt    = {flush_pc[31:1], 1'b0};
            w_state_nxt = flush_pc[1] ? S_SKIP : S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept && w_low_comp) begin
                        w_hold_nxt  = fetch_data[31:16];
                        w_pc_nxt    = r_pc + 32'd2;
                        w_state_nxt = S_HALF;
                    end else if (w_accept) begin
                        w_pc_nxt    = r_pc + 32'd4;
                    end else begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_HALF: begin
                    if (w_hold_comp && w_load_en) begin
                        w_pc_nxt    = r_pc + 32'd2;
                        w_state_nxt = S_EMPTY;
                    end else if (!w_hold_comp && w_accept) begin
                        // Upper half of this word becomes the next leftover.
                        w_pc_nxt    = r_pc + 32'd4;
                        w_hold_nxt  = fetch_data[31:16];
                    end else begin
                        w_state_nxt = S_HALF;
                    end
                end
                S_SKIP: begin
                    if (w_accept) begin
                        w_hold_nxt  = fetch_data[31:16];
                        w_state_nxt = S_HALF;
                    end else begin
                        w_state_nxt = S_SKIP;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    // Output decode: fetch handshake and the instruction to emit this cycle.
    always_comb begin
        w_fetch_ready = 1'b0;
        w_emit        = 1'b0;
        w_emit_instr  = NOP_INSTR;
        if (!reset_n || flush) begin
            w_fetch_ready = 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    w_fetch_ready = w_load_en;
                    w_emit        = fetch_valid && w_load_en;
                    w_emit_instr  = w_low_comp ? {16'h0000, fetch_data[15:0]} : fetch_data;
                end
                S_HALF: begin
                    if (w_hold_comp) begin
                        // Leftover is a whole instruction: drain it without fetching.
                        w_fetch_ready = 1'b0;
                        w_emit        = w_load_en;
                        w_emit_instr  = {16'h0000, r_hold};
                    end else begin
                        w_fetch_ready = w_load_en;
                        w_emit        = fetch_valid && w_load_en;
                        w_emit_instr  = {fetch_data[15:0], r_hold};
                    end
                end
                S_SKIP: begin
                    // Only the upper half is wanted, so nothing is emitted.
                    w_fetch_ready = 1'b1;
                end
                default: begin
                    w_fetch_ready = 1'b0;
                end
            endcase
        end
    end

    // Output register: loads a new instruction or bubble only when load_en.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid      <= 1'b0;
            r_out_instr      <= NOP_INSTR;
            r_out_compressed <= 1'b0;
            r_out_pc         <= RESET_PC;
        end else if (flush) begin
            r_out_valid      <= 1'b0;
        end else if (w_load_en && w_emit) begin
            r_out_valid      <= 1'b1;
            r_out_instr      <= w_emit_instr;
            r_out_compressed <= is_compressed(w_emit_instr[15:0]);
            r_out_pc         <= r_pc;
        end else if (w_load_en) begin
            r_out_valid      <= 1'b0;
        end else begin
            r_out_valid      <= r_out_valid;
        end
    end

endmodule
